pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage pipelined RV32I core (IF/ID/EX/MEM/WB).
- Consumes decoded hazard information from ID/EX/MEM (regwrite_en, wb_src, register indices, branch/jump resolution, data-memory handshake) and drives per-stage pipeline-register enables and flushes.
- Adds a data-memory wait timeout with a sticky error, plus saturating stall and flush performance counters.

Parameters:
- MEM_TIMEOUT, 200, consecutive not-ready MEM cycles after which the ERROR state is entered (1..2^TO_W-1).
- TO_W, 8, width of the wait counter.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs1  in  5  rs1 of the instruction in ID
- id_rs2  in  5  rs2 of the instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  destination register of the instruction in EX
- ex_regwrite_en  in  1  EX instruction writes the register file
- ex_wb_src  in  2  EX writeback source; 2'b01 = MEM, i.e. a load
- ex_redirect  in  1  taken branch, JAL or JALR resolved in EX
- mem_req  in  1  MEM-stage instruction is a load or store
- mem_ready  in  1  data memory completes the access this cycle
- clr_cnt  in  1  synchronous clear of both performance counters
- pc_en  out  1  PC update enable
- if_id_en  out  1  IF/ID register enable
- id_ex_en  out  1  ID/EX register enable
- ex_mem_en  out  1  EX/MEM register enable
- mem_wb_en  out  1  MEM/WB register enable
- if_id_flush  out  1  load NOP into IF/ID; honoured only when if_id_en=1
- id_ex_flush  out  1  load a bubble into ID/EX (regwrite_en=0, memwrite_en=0, B_J=000)
- mem_wb_flush  out  1  load a bubble into MEM/WB
- mem_timeout_err  out  1  sticky timeout error
- stall_cnt  out  CNT_W  number of cycles with pc_en=0 in RUN or MEM_WAIT
- flush_cnt  out  CNT_W  number of accepted redirects

Behaviour:
- States: INIT, RUN, MEM_WAIT, ERROR. Reset enters INIT.
- While rst_n=0, all outputs are 0 and both counters are 0.
- INIT (one cycle after reset release):
  - Outputs: pc_en=0; if_id_en=id_ex_en=ex_mem_en=mem_wb_en=1; if_id_flush=id_ex_flush=mem_wb_flush=1.
  - Next state: RUN.
- Definitions:
  - mem_stall = mem_req & !mem_ready.
  - load_use = ex_regwrite_en & (ex_wb_src==2'b01) & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- RUN and MEM_WAIT share one combinational output decode, highest priority first:
  1. mem_stall: pc_en=if_id_en=id_ex_en=ex_mem_en=0; mem_wb_en=1, mem_wb_flush=1. A redirect or load-use present this cycle is not acted on. ex_redirect stays asserted while EX is frozen and is accepted on the release cycle.
  2. ex_redirect: all enables 1; if_id_flush=1, id_ex_flush=1. Redirect overrides load_use because the ID instruction is wrong-path. flush_cnt increments.
  3. load_use: pc_en=0, if_id_en=0, id_ex_en=1 with id_ex_flush=1, ex_mem_en=mem_wb_en=1. This gives exactly one bubble, since the load moves on to MEM next cycle.
  4. Otherwise: all enables 1, all flushes 0.
- Transitions and wait counter:
  - RUN -> MEM_WAIT on mem_stall; wait_cnt loads 1.
  - In MEM_WAIT, each mem_stall cycle increments wait_cnt.
  - mem_ready=1 (or mem_req=0) in MEM_WAIT: the pipeline advances that same cycle per rules 2-4, and the state returns to RUN.
  - When mem_stall occurs with wait_cnt==MEM_TIMEOUT: go to ERROR and set mem_timeout_err.
- ERROR:
  - All enables 0, all flushes 0, mem_timeout_err=1.
  - Counters hold, and clr_cnt is ignored.
  - Exit is by reset only.
- Counters:
  - stall_cnt +1 on every RUN/MEM_WAIT cycle with pc_en=0.
  - Both counters saturate at all-ones and never wrap.
  - clr_cnt has priority over an increment in the same cycle; the counter reads 0 the next cycle.
- Reset asserted mid-stall: immediate return to INIT values; no partial state persists.
- A load in EX with ex_rd=x0 never stalls.

Test Plan:
- Reset release -> cycle 0: pc_en=0 and all flushes=1; cycle 1: RUN with all enables=1, flushes=0, stall_cnt=0.
- `lw x5` in EX (ex_wb_src=01, ex_rd=5) with ID `add x6,x5,x1` (id_use_rs1=1, id_rs1=5) -> one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt=1. Repeat with ex_rd=0 -> no stall.
- Load-use and ex_redirect asserted in the same cycle -> pc_en=1, if_id_flush=id_ex_flush=1; flush_cnt=1, stall_cnt unchanged.
- mem_req=1 with mem_ready low for 3 cycles, ex_redirect=1 throughout -> 3 frozen cycles with mem_wb_flush=1; on the ready cycle the flush is applied; flush_cnt +1, stall_cnt +3.
- MEM_TIMEOUT=4, mem_ready held 0 -> mem_timeout_err rises after the 5th stall cycle; enables stay 0; clr_cnt has no effect; rst_n pulse clears to INIT.
- Preload stall_cnt near all-ones (CNT_W=4, 14 stalls), then 3 more stalls -> reads 15 and holds; clr_cnt together with a stall -> 0 next cycle.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage RV32I pipeline: resolves memory waits,
// redirects and load-use hazards into per-stage enables and flushes.
module pipeline_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 200,
   parameter int unsigned TO_W        = 8,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_regwrite_en,
   input  logic [1:0]       ex_wb_src,
   input  logic             ex_redirect,
   input  logic             mem_req,
   input  logic             mem_ready,
   input  logic             clr_cnt,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             mem_wb_flush,
   output logic             mem_timeout_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      INIT     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2,
      ERROR    = 2'd3
   } state_e;

   localparam logic [TO_W-1:0]  TimeoutVal = TO_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};

   state_e            state_q, state_d;
   logic [TO_W-1:0]   waitCnt_q, waitCnt_d;
   logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;
   logic [CNT_W-1:0]  flushCnt_q, flushCnt_d;

   logic memStall;
   logic loadUse;
   logic active;
   logic pcEn, ifIdEn, idExEn, exMemEn, memWbEn;
   logic ifIdFlush, idExFlush, memWbFlush, timeoutErr;
   logic redirectTaken;

   assign memStall = mem_req & ~mem_ready;
   assign loadUse  = ex_regwrite_en & (ex_wb_src == 2'b01) & (ex_rd != 5'd0) &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) |
                      (id_use_rs2 & (id_rs2 == ex_rd)));
   assign active   = (state_q == RUN) || (state_q == MEM_WAIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= INIT;
         waitCnt_q  <= '0;
         stallCnt_q <= '0;
         flushCnt_q <= '0;
      end else begin
         state_q    <= state_d;
         waitCnt_q  <= waitCnt_d;
         stallCnt_q <= stallCnt_d;
         flushCnt_q <= flushCnt_d;
      end
   end

   // waitCnt counts consecutive not-ready cycles, including the one that left RUN
   always_comb begin
      state_d   = state_q;
      waitCnt_d = waitCnt_q;
      unique case (state_q)
         INIT: begin
            state_d   = RUN;
            waitCnt_d = '0;
         end
         RUN: begin
            if (memStall) begin
               state_d   = MEM_WAIT;
               waitCnt_d = TO_W'(1);
            end
         end
         MEM_WAIT: begin
            if (memStall) begin
               if (waitCnt_q == TimeoutVal) begin
                  state_d = ERROR;
               end else begin
                  waitCnt_d = waitCnt_q + TO_W'(1);
               end
            end else begin
               state_d   = RUN;
               waitCnt_d = '0;
            end
         end
         ERROR: begin
            state_d = ERROR;
         end
         default: begin
            state_d   = INIT;
            waitCnt_d = '0;
         end
      endcase
   end

   // RUN and MEM_WAIT share a single priority decode: mem wait, redirect, load-use
   always_comb begin
      pcEn          = 1'b0;
      ifIdEn        = 1'b0;
      idExEn        = 1'b0;
      exMemEn       = 1'b0;
      memWbEn       = 1'b0;
      ifIdFlush     = 1'b0;
      idExFlush     = 1'b0;
      memWbFlush    = 1'b0;
      timeoutErr    = 1'b0;
      redirectTaken = 1'b0;
      unique case (state_q)
         INIT: begin
            ifIdEn     = 1'b1;
            idExEn     = 1'b1;
            exMemEn    = 1'b1;
            memWbEn    = 1'b1;
            ifIdFlush  = 1'b1;
            idExFlush  = 1'b1;
            memWbFlush = 1'b1;
         end
         RUN, MEM_WAIT: begin
            if (memStall) begin
               memWbEn    = 1'b1;
               memWbFlush = 1'b1;
            end else if (ex_redirect) begin
               pcEn          = 1'b1;
               ifIdEn        = 1'b1;
               idExEn        = 1'b1;
               exMemEn       = 1'b1;
               memWbEn       = 1'b1;
               ifIdFlush     = 1'b1;
               idExFlush     = 1'b1;
               redirectTaken = 1'b1;
            end else if (loadUse) begin
               idExEn    = 1'b1;
               idExFlush = 1'b1;
               exMemEn   = 1'b1;
               memWbEn   = 1'b1;
            end else begin
               pcEn    = 1'b1;
               ifIdEn  = 1'b1;
               idExEn  = 1'b1;
               exMemEn = 1'b1;
               memWbEn = 1'b1;
            end
         end
         ERROR: begin
            timeoutErr = 1'b1;
         end
         default: begin
            timeoutErr = 1'b0;
         end
      endcase
   end

   // Counters saturate; a clear wins over an increment but is ignored once in ERROR
   always_comb begin
      stallCnt_d = stallCnt_q;
      flushCnt_d = flushCnt_q;
      if (state_q != ERROR) begin
         if (clr_cnt) begin
            stallCnt_d = '0;
            flushCnt_d = '0;
         end else begin
            if (active && !pcEn && (stallCnt_q != CntMax)) begin
               stallCnt_d = stallCnt_q + CNT_W'(1);
            end
            if (redirectTaken && (flushCnt_q != CntMax)) begin
               flushCnt_d = flushCnt_q + CNT_W'(1);
            end
         end
      end
   end

   // State is INIT throughout reset, so the control outputs are forced low here
   assign pc_en           = pcEn & rst_n;
   assign if_id_en        = ifIdEn & rst_n;
   assign id_ex_en        = idExEn & rst_n;
   assign ex_mem_en       = exMemEn & rst_n;
   assign mem_wb_en       = memWbEn & rst_n;
   assign if_id_flush     = ifIdFlush & rst_n;
   assign id_ex_flush     = idExFlush & rst_n;
   assign mem_wb_flush    = memWbFlush & rst_n;
   assign mem_timeout_err = timeoutErr & rst_n;
   assign stall_cnt       = stallCnt_q;
   assign flush_cnt       = flushCnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a vector table for single-cycle decode,
// plus hand sequences for memory wait, saturation, timeout and reset.
module tb_pipeline_hazard_ctrl;

   typedef struct {
      string       name;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        useRs1;
      logic        useRs2;
      logic [4:0]  exRd;
      logic        exRegwrite;
      logic [1:0]  exWbSrc;
      logic        exRedirect;
      logic        clrCnt;
      logic [7:0]  expCtrl;
      logic [31:0] expStall;
      logic [31:0] expFlush;
   } vec_t;

   // ctrl packing: {pc, if_id, id_ex, ex_mem, mem_wb, if_id_fl, id_ex_fl, mem_wb_fl}
   localparam logic [7:0] CtrlInit  = 8'b0111_1111;
   localparam logic [7:0] CtrlRun   = 8'b1111_1000;
   localparam logic [7:0] CtrlLoad  = 8'b0011_1010;
   localparam logic [7:0] CtrlRedir = 8'b1111_1110;
   localparam logic [7:0] CtrlMem   = 8'b0000_1001;
   localparam logic [7:0] CtrlZero  = 8'b0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  idRs1, idRs2, exRd;
   logic        idUseRs1, idUseRs2, exRegwriteEn, exRedirect;
   logic [1:0]  exWbSrc;
   logic        memReq, memReady, clrCnt;

   logic        pcEn, ifIdEn, idExEn, exMemEn, memWbEn;
   logic        ifIdFlush, idExFlush, memWbFlush, memTimeoutErr;
   logic [31:0] stallCnt, flushCnt;

   logic        pcEnS, ifIdEnS, idExEnS, exMemEnS, memWbEnS;
   logic        ifIdFlushS, idExFlushS, memWbFlushS, memTimeoutErrS;
   logic [3:0]  stallCntS, flushCntS;

   wire [7:0] ctrl  = {pcEn, ifIdEn, idExEn, exMemEn, memWbEn, ifIdFlush, idExFlush, memWbFlush};
   wire [7:0] ctrlS = {pcEnS, ifIdEnS, idExEnS, exMemEnS, memWbEnS, ifIdFlushS, idExFlushS, memWbFlushS};

   int compared   = 0;
   int mismatched = 0;

   vec_t vecs[$];

   always #5 clk = ~clk;

   pipeline_hazard_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(idRs1), .id_rs2(idRs2), .id_use_rs1(idUseRs1), .id_use_rs2(idUseRs2),
      .ex_rd(exRd), .ex_regwrite_en(exRegwriteEn), .ex_wb_src(exWbSrc),
      .ex_redirect(exRedirect), .mem_req(memReq), .mem_ready(memReady), .clr_cnt(clrCnt),
      .pc_en(pcEn), .if_id_en(ifIdEn), .id_ex_en(idExEn), .ex_mem_en(exMemEn),
      .mem_wb_en(memWbEn), .if_id_flush(ifIdFlush), .id_ex_flush(idExFlush),
      .mem_wb_flush(memWbFlush), .mem_timeout_err(memTimeoutErr),
      .stall_cnt(stallCnt), .flush_cnt(flushCnt)
   );

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .TO_W(8), .CNT_W(4)) dutSmall (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(idRs1), .id_rs2(idRs2), .id_use_rs1(idUseRs1), .id_use_rs2(idUseRs2),
      .ex_rd(exRd), .ex_regwrite_en(exRegwriteEn), .ex_wb_src(exWbSrc),
      .ex_redirect(exRedirect), .mem_req(memReq), .mem_ready(memReady), .clr_cnt(clrCnt),
      .pc_en(pcEnS), .if_id_en(ifIdEnS), .id_ex_en(idExEnS), .ex_mem_en(exMemEnS),
      .mem_wb_en(memWbEnS), .if_id_flush(ifIdFlushS), .id_ex_flush(idExFlushS),
      .mem_wb_flush(memWbFlushS), .mem_timeout_err(memTimeoutErrS),
      .stall_cnt(stallCntS), .flush_cnt(flushCntS)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mkVec(input string name, input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic u1, input logic u2, input logic [4:0] rd,
                                  input logic rw, input logic [1:0] wb, input logic redir,
                                  input logic clr, input logic [7:0] ctrlExp,
                                  input logic [31:0] s, input logic [31:0] f);
      vec_t v;
      v.name = name; v.rs1 = rs1; v.rs2 = rs2; v.useRs1 = u1; v.useRs2 = u2;
      v.exRd = rd; v.exRegwrite = rw; v.exWbSrc = wb; v.exRedirect = redir;
      v.clrCnt = clr; v.expCtrl = ctrlExp; v.expStall = s; v.expFlush = f;
      return v;
   endfunction

   task automatic setIdle();
      idRs1 = '0; idRs2 = '0; idUseRs1 = 0; idUseRs2 = 0;
      exRd = '0; exRegwriteEn = 0; exWbSrc = 2'b00; exRedirect = 0;
      memReq = 0; memReady = 0; clrCnt = 0;
   endtask

   task automatic setLoadUse();
      idRs1 = 5'd5; idUseRs1 = 1; exRd = 5'd5; exRegwriteEn = 1; exWbSrc = 2'b01;
   endtask

   task automatic applyStimulus(input vec_t v);
      idRs1 = v.rs1; idRs2 = v.rs2; idUseRs1 = v.useRs1; idUseRs2 = v.useRs2;
      exRd = v.exRd; exRegwriteEn = v.exRegwrite; exWbSrc = v.exWbSrc;
      exRedirect = v.exRedirect; clrCnt = v.clrCnt; memReq = 0; memReady = 0;
   endtask

   initial begin
      // counters in each record are the values visible before that cycle's edge
      vecs.push_back(mkVec("idle0",      0, 0, 0, 0, 0, 0, 2'b00, 0, 0, CtrlRun,   0, 0));
      vecs.push_back(mkVec("luRs1",      5, 1, 1, 0, 5, 1, 2'b01, 0, 0, CtrlLoad,  0, 0));
      vecs.push_back(mkVec("idle1",      0, 0, 0, 0, 0, 0, 2'b00, 0, 0, CtrlRun,   1, 0));
      vecs.push_back(mkVec("luRdZero",   0, 0, 1, 1, 0, 1, 2'b01, 0, 0, CtrlRun,   1, 0));
      vecs.push_back(mkVec("luRs2",      3, 7, 0, 1, 7, 1, 2'b01, 0, 0, CtrlLoad,  1, 0));
      vecs.push_back(mkVec("rs2Unused",  0, 7, 0, 0, 7, 1, 2'b01, 0, 0, CtrlRun,   2, 0));
      vecs.push_back(mkVec("aluSrc",     5, 0, 1, 0, 5, 1, 2'b00, 0, 0, CtrlRun,   2, 0));
      vecs.push_back(mkVec("wbSrc11",    5, 0, 1, 0, 5, 1, 2'b11, 0, 0, CtrlRun,   2, 0));
      vecs.push_back(mkVec("noRegwr",    5, 0, 1, 0, 5, 0, 2'b01, 0, 0, CtrlRun,   2, 0));
      vecs.push_back(mkVec("rdDiffers",  6, 4, 1, 1, 5, 1, 2'b01, 0, 0, CtrlRun,   2, 0));
      vecs.push_back(mkVec("luRedirect", 5, 0, 1, 0, 5, 1, 2'b01, 1, 0, CtrlRedir, 2, 0));
      vecs.push_back(mkVec("idle2",      0, 0, 0, 0, 0, 0, 2'b00, 0, 0, CtrlRun,   2, 1));
      vecs.push_back(mkVec("clrIdle",    0, 0, 0, 0, 0, 0, 2'b00, 0, 1, CtrlRun,   2, 1));
      vecs.push_back(mkVec("idle3",      0, 0, 0, 0, 0, 0, 2'b00, 0, 0, CtrlRun,   0, 0));
      vecs.push_back(mkVec("luClr",      5, 0, 1, 0, 5, 1, 2'b01, 0, 1, CtrlLoad,  0, 0));
      vecs.push_back(mkVec("idle4",      0, 0, 0, 0, 0, 0, 2'b00, 0, 0, CtrlRun,   0, 0));

      rst_n = 0;
      setIdle();
      @(negedge clk);
      #1;
      checkOutput("rst.ctrl",  {24'd0, ctrl}, 32'd0);
      checkOutput("rst.err",   {31'd0, memTimeoutErr}, 32'd0);
      checkOutput("rst.stall", stallCnt, 32'd0);
      checkOutput("rst.flush", flushCnt, 32'd0);
      checkOutput("rst.ctrlS", {24'd0, ctrlS}, 32'd0);

      rst_n = 1;
      #1;
      checkOutput("init.ctrl",  {24'd0, ctrl},  {24'd0, CtrlInit});
      checkOutput("init.ctrlS", {24'd0, ctrlS}, {24'd0, CtrlInit});
      checkOutput("init.err",   {31'd0, memTimeoutErr}, 32'd0);

      foreach (vecs[i]) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("%s.ctrl", vecs[i].name),  {24'd0, ctrl}, {24'd0, vecs[i].expCtrl});
         checkOutput($sformatf("%s.ctrlS", vecs[i].name), {24'd0, ctrlS}, {24'd0, vecs[i].expCtrl});
         checkOutput($sformatf("%s.stall", vecs[i].name), stallCnt, vecs[i].expStall);
         checkOutput($sformatf("%s.flush", vecs[i].name), flushCnt, vecs[i].expFlush);
      end

      // three frozen cycles with redirect and load-use pending, then the ready cycle
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         setIdle();
         setLoadUse();
         exRedirect = 1; memReq = 1; memReady = 0;
         #1;
         checkOutput($sformatf("memWait%0d.ctrl", i), {24'd0, ctrl}, {24'd0, CtrlMem});
         checkOutput($sformatf("memWait%0d.stall", i), stallCnt, 32'(i));
         checkOutput($sformatf("memWait%0d.flush", i), flushCnt, 32'd0);
      end
      @(negedge clk);
      memReady = 1;
      #1;
      checkOutput("memReady.ctrl",  {24'd0, ctrl},  {24'd0, CtrlRedir});
      checkOutput("memReady.ctrlS", {24'd0, ctrlS}, {24'd0, CtrlRedir});
      @(negedge clk);
      setIdle();
      #1;
      checkOutput("afterMem.ctrl",  {24'd0, ctrl}, {24'd0, CtrlRun});
      checkOutput("afterMem.stall", stallCnt, 32'd3);
      checkOutput("afterMem.flush", flushCnt, 32'd1);
      checkOutput("afterMem.errS",  {31'd0, memTimeoutErrS}, 32'd0);

      // saturation of the 4-bit counters in dutSmall
      @(negedge clk);
      clrCnt = 1;
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         setIdle();
         setLoadUse();
         #1;
         checkOutput($sformatf("sat%0d.stallS", i), {28'd0, stallCntS}, (i > 15) ? 32'd15 : 32'(i));
         checkOutput($sformatf("sat%0d.stall", i), stallCnt, 32'(i));
      end
      @(negedge clk);
      clrCnt = 1;
      #1;
      checkOutput("satClr.stallS", {28'd0, stallCntS}, 32'd15);
      checkOutput("satClr.stall",  stallCnt, 32'd17);
      @(negedge clk);
      setIdle();
      #1;
      checkOutput("afterClr.stallS", {28'd0, stallCntS}, 32'd0);
      checkOutput("afterClr.stall",  stallCnt, 32'd0);

      // memory never ready: dutSmall times out after its fifth stall cycle
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         memReq = 1; memReady = 0;
         #1;
         checkOutput($sformatf("to%0d.ctrlS", i),  {24'd0, ctrlS}, {24'd0, CtrlMem});
         checkOutput($sformatf("to%0d.errS", i),   {31'd0, memTimeoutErrS}, 32'd0);
         checkOutput($sformatf("to%0d.stallS", i), {28'd0, stallCntS}, 32'(i));
      end
      @(negedge clk);
      #1;
      checkOutput("err.errS",   {31'd0, memTimeoutErrS}, 32'd1);
      checkOutput("err.ctrlS",  {24'd0, ctrlS}, {24'd0, CtrlZero});
      checkOutput("err.stallS", {28'd0, stallCntS}, 32'd5);
      checkOutput("err.err",    {31'd0, memTimeoutErr}, 32'd0);
      checkOutput("err.ctrl",   {24'd0, ctrl}, {24'd0, CtrlMem});
      @(negedge clk);
      clrCnt = 1;
      #1;
      checkOutput("errClr.ctrlS", {24'd0, ctrlS}, {24'd0, CtrlZero});
      @(negedge clk);
      clrCnt = 0;
      #1;
      checkOutput("errHold.stallS", {28'd0, stallCntS}, 32'd5);
      checkOutput("errHold.errS",   {31'd0, memTimeoutErrS}, 32'd1);

      // asynchronous reset in the middle of a stall
      rst_n = 0;
      #1;
      checkOutput("midRst.ctrl",   {24'd0, ctrl},  32'd0);
      checkOutput("midRst.ctrlS",  {24'd0, ctrlS}, 32'd0);
      checkOutput("midRst.errS",   {31'd0, memTimeoutErrS}, 32'd0);
      checkOutput("midRst.stallS", {28'd0, stallCntS}, 32'd0);
      checkOutput("midRst.stall",  stallCnt, 32'd0);
      @(negedge clk);
      setIdle();
      rst_n = 1;
      #1;
      checkOutput("reInit.ctrl",  {24'd0, ctrl},  {24'd0, CtrlInit});
      checkOutput("reInit.ctrlS", {24'd0, ctrlS}, {24'd0, CtrlInit});
      @(negedge clk);
      #1;
      checkOutput("reRun.ctrl",   {24'd0, ctrl},  {24'd0, CtrlRun});
      checkOutput("reRun.ctrlS",  {24'd0, ctrlS}, {24'd0, CtrlRun});
      checkOutput("reRun.errS",   {31'd0, memTimeoutErrS}, 32'd0);
      checkOutput("reRun.stallS", {28'd0, stallCntS}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
